// File: rtl/egress_frame_scheduler.sv
// rtl/egress_frame_scheduler.sv - per-egress round-robin frame scheduler over ingress VOQs
// Optional WAIT watchdog enabled by defining SCHED_WATCHDOG_EN.
module egress_frame_scheduler #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 10,
  parameter int IFG_CYCLES = 12,
  parameter int WDT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          voq_nonempty_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   voq_head_ptr_i,
  input  logic                          rd_ready_i,
  input  logic                          frame_done_i,
  output logic [NUM_PORTS-1:0]          voq_pop_o,
  output logic                          rd_start_o,
  output logic [ADDR_W-1:0]             rd_start_ptr_o,
  output logic [$clog2(NUM_PORTS)-1:0]  sel_port_o,
  output logic                          busy_o,
  output logic                          wdt_timeout_o
);

  localparam int SEL_W = $clog2(NUM_PORTS);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  sel_port_q, sel_port_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [SEL_W-1:0]  winner;
  logic              wdt_fire;

  // Rotating priority: first requester at or above rr_ptr, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!found && voq_nonempty_i[idx]) begin
        found  = 1'b1;
        winner = SEL_W'(idx);
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

  // A real done in the same cycle wins over the timeout.
  assign wdt_fire = (state_q == S_WAIT) && (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) && !frame_done_i;

  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    if (state_q == S_ISSUE) begin
      wdt_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wdt_cnt_d = wdt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  assign wdt_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_port_d  = sel_port_q;
    start_ptr_d = start_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rd_ready_i && (|voq_nonempty_i)) begin
          sel_port_d  = winner;
          start_ptr_d = voq_head_ptr_i[int'(winner)*ADDR_W +: ADDR_W];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sel_port_q == SEL_W'(NUM_PORTS - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = sel_port_q + 1'b1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (frame_done_i || wdt_fire) begin
          if (IFG_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_W'(IFG_CYCLES - 1);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      sel_port_q  <= '0;
      start_ptr_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_port_q  <= sel_port_d;
      start_ptr_q <= start_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    voq_pop_o = '0;
    if (state_q == S_ISSUE) begin
      voq_pop_o[sel_port_q] = 1'b1;
    end
  end

  assign rd_start_o     = (state_q == S_ISSUE);
  assign rd_start_ptr_o = start_ptr_q;
  assign sel_port_o     = sel_port_q;
  assign busy_o         = (state_q != S_IDLE);
  assign wdt_timeout_o  = wdt_fire;

endmodule

// File: tb/tb_egress_frame_scheduler.sv
// tb/tb_egress_frame_scheduler.sv - directed bench for egress_frame_scheduler
// Watchdog checks are compiled in when SCHED_WATCHDOG_EN is defined.
module tb_egress_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  nonempty;
  logic [9:0]  head [4];
  logic [39:0] head_bus;
  logic        rd_ready;
  logic        frame_done;
  logic [3:0]  pop;
  logic        rd_start;
  logic [9:0]  start_ptr;
  logic [1:0]  sel_port;
  logic        busy;
  logic        wdt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int inv_bad    = 0;
  int wdt_pulses = 0;

  always #5 clk = ~clk;

  assign head_bus = {head[3], head[2], head[1], head[0]};

  egress_frame_scheduler #(
    .NUM_PORTS(4), .ADDR_W(10), .IFG_CYCLES(12), .WDT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .voq_nonempty_i(nonempty),
    .voq_head_ptr_i(head_bus),
    .rd_ready_i(rd_ready),
    .frame_done_i(frame_done),
    .voq_pop_o(pop),
    .rd_start_o(rd_start),
    .rd_start_ptr_o(start_ptr),
    .sel_port_o(sel_port),
    .busy_o(busy),
    .wdt_timeout_o(wdt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pop must be one-hot or zero and coincide exactly with the start strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (((pop & (pop - 4'd1)) != 4'd0) || ((pop != 4'd0) != rd_start))
        inv_bad <= inv_bad + 1;
      if (wdt)
        wdt_pulses <= wdt_pulses + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input int max, output int sc, output logic ok);
    ok = 1'b0;
    sc = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rd_start) begin
        ok = 1'b1;
        sc = cyc;
        break;
      end
    end
  endtask

  task automatic run_frame(input string tag, input int exp_sel, input logic [9:0] exp_ptr,
                           input int dly, output int sc);
    logic ok;
    wait_start(400, sc, ok);
    check_eq({tag, "_start"}, 32'(ok), 32'd1);
    if (ok) begin
      check_eq({tag, "_sel"}, 32'(sel_port), 32'(exp_sel));
      check_eq({tag, "_ptr"}, 32'(start_ptr), 32'(exp_ptr));
      check_eq({tag, "_pop"}, 32'(pop), 32'd1 << exp_sel);
      repeat (dly) @(negedge clk);
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
    end
  endtask

  initial begin
    int sc [5];
    int s0;
    int s1;
    int cnt;
    logic ok;

    nonempty   = 4'b0000;
    rd_ready   = 1'b0;
    frame_done = 1'b0;
    head[0] = 10'h011;
    head[1] = 10'h122;
    head[2] = 10'h233;
    head[3] = 10'h344;

    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(rd_start), 32'd0);
    check_eq("rst_pop", 32'(pop), 32'd0);
    check_eq("rst_sel", 32'(sel_port), 32'd0);
    check_eq("rst_ptr", 32'(start_ptr), 32'd0);
    check_eq("rst_wdt", 32'(wdt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four requesting: strict rotation, 5+1+12+1 cycles between starts
    nonempty = 4'b1111;
    rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_frame("rr", k % 4, head[k % 4], 5, sc[k]);
      if (k > 0) check_eq("rr_spacing", 32'(sc[k] - sc[k-1]), 32'd19);
    end

    // rr_ptr is now 1: ports 3 then 0 (wrap)
    nonempty = 4'b1001;
    run_frame("wrap3", 3, head[3], 5, s0);
    run_frame("wrap0", 0, head[0], 5, s1);

    // Held off by rd_ready low
    nonempty = 4'b0010;
    rd_ready = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (rd_start || (pop != 4'd0)) cnt++;
    end
    check_eq("noready_nostart", 32'(cnt), 32'd0);
    rd_ready = 1'b1;
    @(negedge clk);
    check_eq("ready_lat", 32'(rd_start), 32'd1);
    check_eq("ready_sel", 32'(sel_port), 32'd1);
    s0 = cyc;
    @(negedge clk);
    head[1] = 10'h3ff;
    @(negedge clk);
    check_eq("wait_ptr_hold", 32'(start_ptr), 32'h122);
    check_eq("wait_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    repeat (4) @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    check_eq("gap_done_busy", 32'(busy), 32'd1);
    run_frame("after_gap", 1, 10'h3ff, 5, s1);
    check_eq("gap_done_spacing", 32'(s1 - s0), 32'd19);

    // done pulse in IDLE is ignored
    nonempty = 4'b0000;
    repeat (20) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    check_eq("idle_done_busy", 32'(busy), 32'd0);
    check_eq("idle_done_start", 32'(rd_start), 32'd0);

    // Reset while in WAIT
    nonempty = 4'b0100;
    wait_start(100, s0, ok);
    check_eq("pre_rst_start", 32'(ok), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_sel", 32'(sel_port), 32'd0);
    check_eq("midrst_ptr", 32'(start_ptr), 32'd0);
    check_eq("midrst_pop", 32'(pop), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_frame("post_rst", 2, head[2], 5, s0);

`ifdef SCHED_WATCHDOG_EN
    wait_start(100, s0, ok);
    check_eq("wdt_start", 32'(ok), 32'd1);
    s1 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wdt) begin
        s1 = cyc;
        break;
      end
    end
    check_eq("wdt_delay", 32'(s1 - s0), 32'd64);
    @(negedge clk);
    check_eq("wdt_one_cycle", 32'(wdt), 32'd0);
    check_eq("wdt_to_gap", 32'(busy), 32'd1);
    wait_start(100, s0, ok);
    check_eq("wdt2_start", 32'(ok), 32'd1);
    repeat (64) @(negedge clk);
    frame_done = 1'b1;
    #1;
    check_eq("wdt_done_prio", 32'(wdt), 32'd0);
    @(negedge clk);
    frame_done = 1'b0;
`endif

    nonempty = 4'b0000;
    repeat (20) @(negedge clk);
    check_eq("invariants", 32'(inv_bad), 32'd0);
`ifdef SCHED_WATCHDOG_EN
    check_eq("wdt_pulses", 32'(wdt_pulses), 32'd1);
`else
    check_eq("wdt_pulses", 32'(wdt_pulses), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/egress_frame_scheduler.md
Name: egress_frame_scheduler

Overview:
- Per-egress-port frame-level scheduler. Sits between the per-ingress VOQs of one egress port and that port's memory read controller.
- Picks one non-empty VOQ using round-robin over ingress ports, issues the head frame's start pointer to the read controller, and pops the VOQ.
- Holds off the next selection until the read controller reports the frame done, then enforces an inter-frame gap.
- One instance per egress port inside the outputs block.

Parameters:
- NUM_PORTS, 4, number of ingress VOQs feeding this egress port (≥2).
- ADDR_W, 10, SRAM block-address width (matches mem_pkg ADDR_W).
- IFG_CYCLES, 12, idle cycles enforced after each frame (0 = no gap).
- WDT_CYCLES, 4096, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  scheduler clock (switch clock domain).
- rst  in  1  asynchronous active-high reset.
- voq_nonempty_i  in  NUM_PORTS  bit i = VOQ from ingress i holds ≥1 frame.
- voq_head_ptr_i  in  NUM_PORTS*ADDR_W  head start pointer of each VOQ; slice i = bits [i*ADDR_W +: ADDR_W].
- rd_ready_i  in  1  read controller idle and able to accept a new frame.
- frame_done_i  in  1  one-cycle pulse: read controller finished (or freed) the current frame.
- voq_pop_o  out  NUM_PORTS  one-hot, one-cycle dequeue strobe to the winning VOQ.
- rd_start_o  out  1  one-cycle start strobe to the read controller.
- rd_start_ptr_o  out  ADDR_W  start pointer; valid while rd_start_o=1.
- sel_port_o  out  $clog2(NUM_PORTS)  ingress index of the current/last granted frame.
- busy_o  out  1  high in ISSUE, WAIT and GAP.
- wdt_timeout_o  out  1  one-cycle timeout pulse (tied 0 without the optional feature).

Behaviour:
- **Reset:** all outputs 0, state=IDLE, rr_ptr=0, gap counter=0. Reset is asynchronous and may be asserted in any state; the frame in flight is abandoned and no pop or start is reissued.
- **States:** IDLE, ISSUE, WAIT, GAP.
- **IDLE:**
  - When rd_ready_i=1 and |voq_nonempty_i: the winner is the first set bit of voq_nonempty_i at or after rr_ptr, searching upward and wrapping modulo NUM_PORTS.
  - Register winner into sel_port_o and voq_head_ptr_i[winner] into rd_start_ptr_o; go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE (exactly 1 cycle):**
  - rd_start_o=1 and voq_pop_o[sel_port_o]=1.
  - rr_ptr <= (sel_port_o+1) mod NUM_PORTS; go to WAIT.
- **Latency:** request visible in IDLE → rd_start_o one cycle later. Inputs are sampled only in IDLE; changes to voq_nonempty_i or voq_head_ptr_i during ISSUE, WAIT or GAP do not affect the current grant.
- **WAIT:** stay until frame_done_i=1. Then go to GAP if IFG_CYCLES>0, else IDLE.
- **frame_done_i outside WAIT:** ignored. The read controller guarantees at least one cycle between rd_start_o and frame_done_i.
- **GAP:**
  - Load counter with IFG_CYCLES-1 on entry and decrement each cycle.
  - Exit to IDLE in the cycle the counter reads 0, so exactly IFG_CYCLES cycles are spent in GAP.
- **Frame-to-frame spacing:** done pulse → next rd_start_o is at least IFG_CYCLES+2 cycles.
- **Single requester:** one non-empty VOQ is re-granted every frame. rr_ptr still advances past it, so there is no starvation once others become non-empty.
- **Invariants:** rd_start_o and voq_pop_o are never asserted outside ISSUE. voq_pop_o is always one-hot or zero. sel_port_o and rd_start_ptr_o hold their value until the next ISSUE.

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- **Defined:**
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches WDT_CYCLES-1 with no frame_done_i: wdt_timeout_o=1 for one cycle, then move to GAP (or IDLE if IFG_CYCLES=0) exactly as if the frame were done.
  - If frame_done_i coincides with the timeout cycle, frame_done_i takes priority and no timeout is reported.
- **Undefined:** no counter; wdt_timeout_o tied 0; WAIT exits only on frame_done_i.

Test Plan:
- Reset mid-WAIT (rst pulse) → all outputs 0, state IDLE, rr_ptr=0. After release with nonempty=4'b0100 → sel_port_o=2, single pop 4'b0100.
- nonempty=4'b1111, rd_ready=1, done 5 cycles after each start, IFG=12 → grant order 0,1,2,3,0. Start strobes separated by exactly 5+1+12+1 cycles.
- nonempty=4'b1001, rr_ptr=1 → winner 3 with rd_start_ptr_o=head[3]. Next frame: winner 0 (wrap-around).
- rd_ready_i=0 for 20 cycles with nonempty=4'b0010 → no start/pop. rd_ready_i rises → rd_start_o exactly 1 cycle later.
- frame_done_i pulsed in IDLE and in GAP → ignored, no state change. head_ptr changes during WAIT → rd_start_ptr_o unchanged.
- With SCHED_WATCHDOG_EN, WDT_CYCLES=64, done never sent → wdt_timeout_o pulses once 64 cycles after entering WAIT, then GAP. Done on cycle 63 → no timeout.
